// File: rtl/local_port_buffer.sv
// Local injection-port FIFO with a one-write-per-request upstream handshake and FWFT downstream port.
// Optional statistics counters are enabled by defining LOCAL_BUF_STATS_EN.
module local_port_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReqUpStr,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    output logic                  ReqDnStr,
    input  logic                  GntDnStr,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic                  Empty
`ifdef LOCAL_BUF_STATS_EN
    ,
    output logic [15:0]           PktInCnt,
    output logic [15:0]           PktOutCnt,
    output logic [ADDR_W:0]       MaxOcc
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_gnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_nxt;

    // Full decision uses the pre-pop count, so a pop never frees a slot on the same edge.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr    = (r_state == IDLE) && ReqUpStr && !w_full;
    assign w_pop   = GntDnStr && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Upstream handshake: a grant cycle always follows a write, so each request writes once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
        end else if (r_state == GRANT) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
        end else if (w_wr) begin
            r_state <= GRANT;
            r_gnt   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage is not reset; contents are only observable once count says they are valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= PacketIn;
        end
    end

    assign GntUpStr  = r_gnt;
    assign UpStrFull = w_full;
    assign Empty     = w_empty;
    assign ReqDnStr  = !w_empty;
    assign PacketOut = r_mem[r_rd_ptr];

`ifdef LOCAL_BUF_STATS_EN
    logic [15:0]      r_in_cnt;
    logic [15:0]      r_out_cnt;
    logic [CNT_W-1:0] r_max_occ;

    // Peak tracks the post-edge count so MaxOcc is current with the occupancy it reports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_max_occ <= '0;
        end else begin
            if (w_wr) begin
                r_in_cnt <= r_in_cnt + 16'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 16'(1);
            end
            if (w_count_nxt > r_max_occ) begin
                r_max_occ <= w_count_nxt;
            end
        end
    end

    assign PktInCnt  = r_in_cnt;
    assign PktOutCnt = r_out_cnt;
    assign MaxOcc    = r_max_occ;
`endif

endmodule

// File: tb/tb_local_port_buffer.sv
// Self-checking bench for local_port_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_local_port_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk;
    logic          reset;
    logic          ReqUpStr;
    logic [DW-1:0] PacketIn;
    logic          GntUpStr;
    logic          UpStrFull;
    logic          ReqDnStr;
    logic          GntDnStr;
    logic [DW-1:0] PacketOut;
    logic          Empty;
`ifdef LOCAL_BUF_STATS_EN
    logic [15:0]   PktInCnt;
    logic [15:0]   PktOutCnt;
    logic [AW:0]   MaxOcc;
`endif

    local_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .PacketIn  (PacketIn),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .ReqDnStr  (ReqDnStr),
        .GntDnStr  (GntDnStr),
        .PacketOut (PacketOut),
        .Empty     (Empty)
`ifdef LOCAL_BUF_STATS_EN
        ,
        .PktInCnt  (PktInCnt),
        .PktOutCnt (PktOutCnt),
        .MaxOcc    (MaxOcc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet queue, "just granted" flag, statistics.
    logic [DW-1:0] q[$];
    bit            m_gnt = 1'b0;
    int            m_in  = 0;
    int            m_out = 0;
    int            m_max = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt_up", 64'(GntUpStr), 64'(m_gnt));
        chk("req_dn", 64'(ReqDnStr), 64'(q.size() != 0));
        chk("empty", 64'(Empty), 64'(q.size() == 0));
        chk("full", 64'(UpStrFull), 64'(q.size() == DEPTH));
        if (q.size() != 0) chk("pkt_out", 64'(PacketOut), 64'(q[0]));
`ifdef LOCAL_BUF_STATS_EN
        chk("pkt_in_cnt", 64'(PktInCnt), 64'(16'(m_in)));
        chk("pkt_out_cnt", 64'(PktOutCnt), 64'(16'(m_out)));
        chk("max_occ", 64'(MaxOcc), 64'(m_max));
`endif
    endtask

    // Apply inputs for one clock, advance the model by that edge, then compare.
    task automatic step(input logic req, input logic [DW-1:0] pkt, input logic gdn);
        bit wr;
        bit pop;
        ReqUpStr = req;
        PacketIn = pkt;
        GntDnStr = gdn;
        wr  = !m_gnt && req && (q.size() < DEPTH);
        pop = gdn && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            m_out++;
        end
        if (wr) begin
            q.push_back(pkt);
            m_in++;
        end
        m_gnt = wr;
        if (q.size() > m_max) m_max = q.size();
        check_all();
    endtask

    // Hold a request until granted, with a bounded number of cycles.
    task automatic send(input logic [DW-1:0] pkt);
        int n;
        n = 0;
        do begin
            step(1'b1, pkt, 1'b0);
            n++;
        end while (!GntUpStr && n < 20);
        chk("send_granted", 64'(GntUpStr), 64'(1));
    endtask

    task automatic model_reset();
        q.delete();
        m_gnt = 1'b0;
        m_in  = 0;
        m_out = 0;
        m_max = 0;
    endtask

    initial begin
        int            sent;
        int            cyc;
        int            in_base;
        int            out_base;
        logic          cur_req;
        logic [DW-1:0] cur_pkt;

        reset    = 1'b0;
        ReqUpStr = 1'b0;
        PacketIn = '0;
        GntDnStr = 1'b0;
        #3;
        chk("rst_gnt", 64'(GntUpStr), 64'(0));
        chk("rst_full", 64'(UpStrFull), 64'(0));
        chk("rst_empty", 64'(Empty), 64'(1));
        chk("rst_reqdn", 64'(ReqDnStr), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single request, no pops.
        step(1'b1, 32'h0091_0001, 1'b0);
        chk("s1_gnt", 64'(GntUpStr), 64'(1));
        chk("s1_reqdn", 64'(ReqDnStr), 64'(1));
        chk("s1_pkt", 64'(PacketOut), 64'(32'h0091_0001));
        step(1'b0, '0, 1'b0);
        chk("s1_gnt_pulse", 64'(GntUpStr), 64'(0));
        step(1'b0, '0, 1'b1);
        chk("s1_drained", 64'(Empty), 64'(1));
        step(1'b0, '0, 1'b1);

        // Fill to full, then a held 5th request waits for a pop.
        for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i));
        chk("full_after4", 64'(UpStrFull), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hA000_0004, 1'b0);
            chk("held_no_gnt", 64'(GntUpStr), 64'(0));
        end
        // Pop and pending request on the same edge: pop only.
        step(1'b1, 32'hA000_0004, 1'b1);
        chk("pop_only_gnt", 64'(GntUpStr), 64'(0));
        chk("pop_only_full", 64'(UpStrFull), 64'(0));
        chk("pop_only_head", 64'(PacketOut), 64'(32'hA000_0001));
        step(1'b1, 32'hA000_0004, 1'b0);
        chk("late_gnt", 64'(GntUpStr), 64'(1));
        chk("late_full", 64'(UpStrFull), 64'(1));

        // Drain to two, then write and pop on one edge.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'hB000_0001, 1'b1);
        chk("wp_gnt", 64'(GntUpStr), 64'(1));
        chk("wp_head", 64'(PacketOut), 64'(32'hA000_0004));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("wp_empty", 64'(Empty), 64'(1));

        // Ten packets with random downstream grants.
        in_base  = m_in;
        out_base = m_out;
        sent     = 0;
        cyc      = 0;
        cur_req  = 1'b0;
        cur_pkt  = '0;
        while ((sent < 10 || q.size() != 0) && cyc < 300) begin
            if (!cur_req && sent < 10) begin
                cur_req = 1'b1;
                cur_pkt = $urandom;
            end
            step(cur_req, cur_pkt, 1'($urandom_range(0, 1)));
            if (GntUpStr) begin
                cur_req = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("ten_sent", 64'(sent), 64'(10));
        chk("ten_out", 64'(m_out - out_base), 64'(10));
        chk("ten_empty", 64'(Empty), 64'(1));
`ifdef LOCAL_BUF_STATS_EN
        chk("ten_in_stat", 64'(16'(PktInCnt - 16'(in_base))), 64'(10));
        chk("ten_out_stat", 64'(16'(PktOutCnt - 16'(out_base))), 64'(10));
`endif

        // Reset while in GRANT with three stored packets.
        send(32'hC000_0001);
        send(32'hC000_0002);
        send(32'hC000_0003);
        chk("pre_rst_gnt", 64'(GntUpStr), 64'(1));
        ReqUpStr = 1'b0;
        reset    = 1'b0;
        #2;
        model_reset();
        chk("arst_gnt", 64'(GntUpStr), 64'(0));
        chk("arst_empty", 64'(Empty), 64'(1));
        chk("arst_reqdn", 64'(ReqDnStr), 64'(0));
        chk("arst_full", 64'(UpStrFull), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(32'hD000_0001);
        chk("post_rst_pkt", 64'(PacketOut), 64'(32'hD000_0001));

        // Long random traffic with random request arrivals.
        cur_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!cur_req && $urandom_range(0, 2) != 0) begin
                cur_req = 1'b1;
                cur_pkt = $urandom;
            end
            step(cur_req, cur_pkt, 1'($urandom_range(0, 2) == 0));
            if (GntUpStr) cur_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
